// File: rtl/varredura_pkg.sv
// Shared encodings for the sonar sweep control unit: FSM states (which double as
// db_estado codes) and the TX record field indices.
package varredura_pkg;

  typedef enum logic [3:0] {
    INICIAL            = 4'd0,
    PREPARACAO         = 4'd1,
    POSICIONA          = 4'd2,
    ESPERA_SERVO       = 4'd3,
    MEDE               = 4'd4,
    AGUARDA_MEDIDA     = 4'd5,
    TRANSMITE          = 4'd6,
    ESPERA_TRANSMISSAO = 4'd7,
    FIM_POSICAO        = 4'd8,
    FALHA_MEDIDA       = 4'd9
  } estado_t;

  localparam logic [3:0] DB_ILEGAL = 4'hE;

  // Record layout: angle C/D/U, comma, distance C/D/U, terminator.
  localparam logic [2:0] CAMPO_ANG_C   = 3'd0;
  localparam logic [2:0] CAMPO_ANG_D   = 3'd1;
  localparam logic [2:0] CAMPO_ANG_U   = 3'd2;
  localparam logic [2:0] CAMPO_VIRGULA = 3'd3;
  localparam logic [2:0] CAMPO_DIST_C  = 3'd4;
  localparam logic [2:0] CAMPO_DIST_D  = 3'd5;
  localparam logic [2:0] CAMPO_DIST_U  = 3'd6;
  localparam logic [2:0] CAMPO_HASH    = 3'd7;
  localparam logic [2:0] CAMPO_ULTIMO  = CAMPO_HASH;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear, count enable and a terminal-count flag
// (fim is high while the count sits at M-1).
module contador_m #(
  parameter int M = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] valor;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor <= '0;
    end else if (clear) begin
      valor <= '0;
    end else if (enable) begin
      valor <= (valor == ULTIMO) ? '0 : valor + 1'b1;
    end
  end

  assign fim = (valor == ULTIMO);

endmodule

// File: rtl/varredura_uc.sv
// Sonar sweep control unit: ping-pong servo stepping, settle wait, one measurement,
// then an 8-field serial record. Define VARREDURA_TIMEOUT_EN to enable the measurement watchdog.
module varredura_uc
  import varredura_pkg::*;
#(
  parameter int N_POSICOES     = 8,
  parameter int ESPERA_CICLOS  = 50_000_000,
  parameter int TIMEOUT_CICLOS = 10_000_000,
  localparam int PW = (N_POSICOES > 1) ? $clog2(N_POSICOES) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ligar,
  input  logic          pronto_medida,
  input  logic          pronto_serial,
  output logic          mensurar,
  output logic          partida_serial,
  output logic [2:0]    sel_campo,
  output logic [PW-1:0] posicao,
  output logic          pronto,
  output logic          erro_medida,
  output logic [3:0]    db_estado
);

  localparam logic [PW-1:0] POS_MAX = PW'(N_POSICOES - 1);

  estado_t       estado;
  logic [2:0]    campo;
  logic          sobe;
  logic          fim_espera;
  logic          fim_timeout;
  logic [PW-1:0] pos_prox;

  contador_m #(.M(ESPERA_CICLOS)) u_espera (
    .clock  (clock),
    .reset  (reset),
    .clear  (estado == POSICIONA),
    .enable (estado == ESPERA_SERVO),
    .fim    (fim_espera)
  );

`ifdef VARREDURA_TIMEOUT_EN
  contador_m #(.M(TIMEOUT_CICLOS)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (estado == MEDE),
    .enable (estado == AGUARDA_MEDIDA),
    .fim    (fim_timeout)
  );
`else
  assign fim_timeout = 1'b0;
  if (TIMEOUT_CICLOS < 1) begin : g_timeout_invalido
  end
`endif

  assign pos_prox  = sobe ? posicao + 1'b1 : posicao - 1'b1;
  assign sel_campo = campo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado         <= INICIAL;
      campo          <= CAMPO_ANG_C;
      posicao        <= '0;
      sobe           <= 1'b1;
      mensurar       <= 1'b0;
      partida_serial <= 1'b0;
      pronto         <= 1'b0;
      erro_medida    <= 1'b0;
    end else begin
      // Pulse outputs are asserted together with the transition into their state.
      mensurar       <= 1'b0;
      partida_serial <= 1'b0;
      pronto         <= 1'b0;
      erro_medida    <= 1'b0;
      case (estado)
        INICIAL: if (ligar) estado <= PREPARACAO;
        PREPARACAO: begin
          posicao <= '0;
          sobe    <= 1'b1;
          campo   <= CAMPO_ANG_C;
          estado  <= POSICIONA;
        end
        POSICIONA: estado <= ESPERA_SERVO;
        ESPERA_SERVO: if (fim_espera) begin
          estado   <= MEDE;
          mensurar <= 1'b1;
        end
        MEDE: begin
          campo  <= CAMPO_ANG_C;
          estado <= AGUARDA_MEDIDA;
        end
        AGUARDA_MEDIDA: begin
          if (pronto_medida) begin
            estado         <= TRANSMITE;
            partida_serial <= 1'b1;
          end else if (fim_timeout) begin
            estado      <= FALHA_MEDIDA;
            erro_medida <= 1'b1;
          end
        end
        TRANSMITE: estado <= ESPERA_TRANSMISSAO;
        ESPERA_TRANSMISSAO: if (pronto_serial) begin
          if (campo == CAMPO_ULTIMO) begin
            estado <= FIM_POSICAO;
            pronto <= 1'b1;
          end else begin
            campo          <= campo + 1'b1;
            estado         <= TRANSMITE;
            partida_serial <= 1'b1;
          end
        end
        FALHA_MEDIDA: begin
          estado <= FIM_POSICAO;
          pronto <= 1'b1;
        end
        FIM_POSICAO: begin
          if (ligar) begin
            posicao <= pos_prox;
            if (sobe && pos_prox == POS_MAX) sobe <= 1'b0;
            else if (!sobe && pos_prox == '0) sobe <= 1'b1;
            estado <= POSICIONA;
          end else begin
            estado <= INICIAL;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  // NOTE: combinational block assigns its output on every path to avoid an inferred latch.
  always_comb begin
    db_estado = DB_ILEGAL;
    if (estado <= FALHA_MEDIDA) db_estado = 4'(estado);
  end

endmodule

// File: tb/tb_varredura_uc.sv
// Randomized self-checking bench for varredura_uc: transaction-level model of the
// sweep (ping-pong position formula, 8-field record, cycle latencies).
module tb_varredura_uc;

  localparam int N = 4;
  localparam int E = 5;
  localparam int T = 20;
  localparam int PW = $clog2(N);

  logic          clock = 1'b0;
  logic          reset;
  logic          ligar;
  logic          pronto_medida;
  logic          pronto_serial;
  logic          mensurar;
  logic          partida_serial;
  logic [2:0]    sel_campo;
  logic [PW-1:0] posicao;
  logic          pronto;
  logic          erro_medida;
  logic [3:0]    db_estado;

  int total = 0;
  int bad   = 0;
  int n_partida = 0;

  varredura_uc #(.N_POSICOES(N), .ESPERA_CICLOS(E), .TIMEOUT_CICLOS(T)) dut (
    .clock          (clock),
    .reset          (reset),
    .ligar          (ligar),
    .pronto_medida  (pronto_medida),
    .pronto_serial  (pronto_serial),
    .mensurar       (mensurar),
    .partida_serial (partida_serial),
    .sel_campo      (sel_campo),
    .posicao        (posicao),
    .pronto         (pronto),
    .erro_medida    (erro_medida),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (partida_serial === 1'b1) n_partida++;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Ping-pong sweep position of the k-th record after preparacao.
  function automatic int pos_of(input int k);
    int p;
    int r;
    p = 2 * (N - 1);
    r = k % p;
    return (r < N) ? r : p - r;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_mensurar(input int lat, input int k);
    int n;
    n = 0;
    while (mensurar !== 1'b1 && n < lat + 10) begin
      tick();
      n++;
    end
    check("mensurar_latency", n, lat);
    check("posicao_at_mede", posicao, pos_of(k));
    check("db_mede", db_estado, 4);
  endtask

  // Starts in the mede cycle; ends one cycle after pronto (or right after an abort).
  task automatic run_record(input int k, input int drop_field, input int abort_field);
    int d;
    int w;
    int base;
    base = n_partida;
    tick();
    check("db_aguarda", db_estado, 5);
    d = $urandom_range(0, 3);
    repeat (d) begin
      pronto_serial = 1'($urandom_range(0, 1));
      tick();
      pronto_serial = 1'b0;
      check("serial_ignored_in_aguarda", db_estado, 5);
      check("no_partida_in_aguarda", partida_serial, 0);
    end
    pronto_medida = 1'b1;
    tick();
    pronto_medida = 1'b0;
    for (int f = 0; f < 8; f++) begin
      check("partida_pulse", partida_serial, 1);
      check("sel_at_partida", sel_campo, f);
      check("db_transmite", db_estado, 6);
      if (f == abort_field) begin
        #2 reset = 1'b0;
        #1;
        check("rst_mensurar", mensurar, 0);
        check("rst_partida", partida_serial, 0);
        check("rst_pronto", pronto, 0);
        check("rst_erro", erro_medida, 0);
        check("rst_sel", sel_campo, 0);
        check("rst_posicao", posicao, 0);
        check("rst_db", db_estado, 0);
        return;
      end
      tick();
      check("partida_one_cycle", partida_serial, 0);
      check("sel_stable", sel_campo, f);
      w = $urandom_range(0, 3);
      repeat (w) begin
        pronto_medida = 1'($urandom_range(0, 1));
        if (f == drop_field) ligar = 1'b0;
        tick();
        pronto_medida = 1'b0;
        check("medida_ignored_in_tx", db_estado, 7);
        check("sel_during_tx", sel_campo, f);
      end
      if (f == drop_field) ligar = 1'b0;
      pronto_serial = 1'b1;
      tick();
      pronto_serial = 1'b0;
    end
    check("pronto_pulse", pronto, 1);
    check("db_fim", db_estado, 8);
    check("partida_count", n_partida - base, 8);
    tick();
    check("pronto_one_cycle", pronto, 0);
    if (drop_field < 0) begin
      check("db_posiciona", db_estado, 2);
      check("posicao_step", posicao, pos_of(k + 1));
    end else begin
      check("db_back_inicial", db_estado, 0);
      check("posicao_held", posicao, pos_of(k));
    end
  endtask

  initial begin
    int base;
    int seen_erro;
    int not_wait;
    reset = 1'b0;
    ligar = 1'b0;
    pronto_medida = 1'b0;
    pronto_serial = 1'b0;
    repeat (2) tick();
    check("reset_mensurar", mensurar, 0);
    check("reset_partida", partida_serial, 0);
    check("reset_pronto", pronto, 0);
    check("reset_erro", erro_medida, 0);
    check("reset_sel", sel_campo, 0);
    check("reset_posicao", posicao, 0);
    check("reset_db", db_estado, 0);
    reset = 1'b1;
    tick();
    tick();
    check("idle_without_ligar", db_estado, 0);

    // Start-up latency: ligar sampled in inicial is cycle 0.
    ligar = 1'b1;
    for (int c = 1; c <= E + 3; c++) begin
      tick();
      check("startup_db", db_estado, (c == 1) ? 1 : (c == 2) ? 2 : (c <= E + 2) ? 3 : 4);
      check("startup_mensurar", mensurar, (c == E + 3) ? 1 : 0);
    end
    check("first_posicao", posicao, 0);

    run_record(0, -1, -1);
    for (int k = 1; k < 7; k++) begin
      wait_mensurar(E + 1, k);
      run_record(k, -1, -1);
    end
    wait_mensurar(E + 1, 7);
    run_record(7, 3, -1);
    repeat (3) begin
      tick();
      check("stay_inicial", db_estado, 0);
      check("stay_posicao", posicao, pos_of(7));
    end

    // Restart from a held position, then reset in the middle of a record.
    ligar = 1'b1;
    wait_mensurar(E + 3, 0);
    run_record(0, -1, -1);
    wait_mensurar(E + 1, 1);
    run_record(1, -1, 2);
    tick();
    check("in_reset_db", db_estado, 0);
    reset = 1'b1;
    wait_mensurar(E + 3, 0);

    // No pronto_medida: watchdog path or indefinite wait.
    base = n_partida;
    seen_erro = 0;
    not_wait = 0;
    tick();
    check("timeout_db_aguarda", db_estado, 5);
`ifdef VARREDURA_TIMEOUT_EN
    repeat (T - 1) begin
      tick();
      if (erro_medida !== 1'b0) seen_erro++;
      if (db_estado !== 4'd5) not_wait++;
    end
    check("erro_not_early", seen_erro, 0);
    check("waiting_before_timeout", not_wait, 0);
    tick();
    check("erro_pulse", erro_medida, 1);
    check("db_falha", db_estado, 9);
    tick();
    check("erro_one_cycle", erro_medida, 0);
    check("pronto_after_falha", pronto, 1);
    check("db_fim_after_falha", db_estado, 8);
    check("no_tx_on_timeout", n_partida - base, 0);
`else
    repeat (2 * T) begin
      tick();
      if (erro_medida !== 1'b0) seen_erro++;
      if (db_estado !== 4'd5) not_wait++;
    end
    check("erro_tied_low", seen_erro, 0);
    check("waits_forever", not_wait, 0);
    check("no_tx_while_waiting", n_partida - base, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/varredura_uc.md
# varredura_uc

Control unit for the sonar sweep built on top of the trena measurement/transmission datapath. It steps a servo through a ping-pong sequence of positions, waits for the servo to settle, triggers one distance measurement, then sequences the serial transmitter through an 8-field record: 3 angle digits, comma, 3 distance digits, '#'. It sits between the operator enable, the measurement datapath, the field-select mux in front of the serial TX, and the servo PWM position input.

## Interface
- N_POSICOES, 8: number of servo positions in the sweep (≥2)
- ESPERA_CICLOS, 50_000_000: settle cycles spent in espera_servo (≥1)
- TIMEOUT_CICLOS, 10_000_000: measurement watchdog limit (used only with VARREDURA_TIMEOUT_EN)

- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- ligar  in  1  sweep enable, level-sensitive
- pronto_medida  in  1  one-cycle pulse from the measurement datapath: distance valid
- pronto_serial  in  1  one-cycle pulse from serial TX: character sent
- mensurar  out  1  one-cycle measurement trigger
- partida_serial  out  1  one-cycle serial TX start
- sel_campo  out  3  field index for the TX mux (0–2 angle C/D/U, 3 comma, 4–6 distance C/D/U, 7 '#')
- posicao  out  $clog2(N_POSICOES)  current servo position
- pronto  out  1  one-cycle pulse: record for one position finished
- erro_medida  out  1  one-cycle pulse: measurement timed out
- db_estado  out  4  debug state code

## Operation
- States and db_estado codes: inicial 0, preparacao 1, posiciona 2, espera_servo 3, mede 4, aguarda_medida 5, transmite 6, espera_transmissao 7, fim_posicao 8, falha_medida 9. Any illegal state shows E and goes to inicial.
- inicial: ligar=1 goes to preparacao.
- preparacao: clears posicao to 0, direction to up, and campo to 0; goes to posiciona.
- posiciona: clears the settle timer; goes to espera_servo.
- espera_servo: the timer counts; when it reaches ESPERA_CICLOS-1 the FSM goes to mede.
- mede: mensurar=1 for this cycle; clears campo; goes to aguarda_medida.
- aguarda_medida: pronto_medida goes to transmite. pronto_medida is sampled only in this state.
- transmite: partida_serial=1; goes to espera_transmissao.
- espera_transmissao: on pronto_serial, if campo<7 then campo++ and go to transmite; if campo=7 go to fim_posicao. pronto_serial is sampled only in this state.
- fim_posicao: pronto=1. If ligar=1, step posicao and go to posiciona. If ligar=0, go to inicial with posicao held.
- Position stepping is ping-pong: 0,1,…,N-1,N-2,…,0,1,… Direction flips on the step that lands on N-1 or on 0. Nothing wraps around.
- ligar is read only in inicial and fim_posicao. Dropping ligar mid-record always completes the current record.
- sel_campo always equals campo. It is registered and stable during partida_serial and the whole transmission.

## Timing
- Reset values: mensurar=0, partida_serial=0, pronto=0, erro_medida=0, sel_campo=0, posicao=0, db_estado=0, state=inicial.
- Reset asserted mid-operation aborts immediately, including any in-flight pulse; no record is completed.
- Latency from ligar=1 sampled in inicial (cycle 0): preparacao at cycle 1, posiciona at 2, espera_servo at cycles 3 to 2+ESPERA_CICLOS, mensurar at cycle 3+ESPERA_CICLOS.
- Each field costs 2 cycles plus the serial wait. There are 8 partida_serial pulses per record, with sel_campo 0..7 in order.
- The posicao update is visible in the posiciona cycle following fim_posicao.

## Configuration
- VARREDURA_TIMEOUT_EN defined:
  - A counter runs while in aguarda_medida.
  - If it reaches TIMEOUT_CICLOS-1 with no pronto_medida, go to falha_medida.
  - falha_medida: erro_medida=1 for one cycle, no transmission, then go to fim_posicao (pronto still pulses).
  - If pronto_medida and timeout coincide, pronto_medida wins.
- Not defined: no counter; aguarda_medida waits indefinitely; erro_medida is tied to 0; falha_medida is unreachable.

## Structure
- varredura_pkg holds the state encodings, the db_estado codes, the field indices CAMPO_ANG_C..CAMPO_HASH, and the CAMPO_ULTIMO=7 constant.
- One sub-module, contador_m (modulo-M counter with clear, enable, and terminal-count flag). It is instantiated for the settle timer and, under the macro, for the watchdog.

## Test plan
Bench parameters: N_POSICOES=4, ESPERA_CICLOS=5, TIMEOUT_CICLOS=20.
- Reset low mid-transmission → all outputs at reset values on the same edge, db_estado=0.
- ligar=1 from cycle 0 → mensurar at cycle 8; pronto_medida → 8 partida_serial pulses with sel_campo 0..7, then one pronto pulse.
- ligar held over 7 records → posicao sequence 0,1,2,3,2,1,0.
- ligar dropped during field 3 → fields 4..7 still sent, pronto pulses, state returns to inicial, posicao held.
- pronto_serial pulsed during aguarda_medida, and pronto_medida pulsed during espera_transmissao → both ignored, no state change.
- With VARREDURA_TIMEOUT_EN and no pronto_medida → erro_medida 20 cycles after entering aguarda_medida, zero partida_serial pulses, pronto next cycle. Without the macro → stays in state 5 and erro_medida stays 0.
